stopwatch_ctrl: RTL and testbench

- Control sequencer for the stopwatch Counter datapath; sits between the board buttons/switches and the Counter.
- Debounces the raw inputs and runs a mode FSM (IDLE/RUN/PAUSE/ADJUST).
- Generates Counter stimulus: tick enable, clear, pause, sel, and the display blink enable.
- Replaces direct wiring of buttons into the Counter.

---
 rtl/stopwatch_ctrl_if.sv | 25 ++
 rtl/stopwatch_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
`timescale 1ns/1ps
// Board-side inputs and Counter-side stimulus of the stopwatch control sequencer.
// master: the sequencer; slave: the buttons/Counter side (or a bench).
interface stopwatch_ctrl_if;
    logic       btn_pause;
    logic       btn_rst;
    logic       sw_adj;
    logic       sw_sel;
    logic       ticker;
    logic       cnt_clr;
    logic       cnt_pause;
    logic       cnt_sel;
    logic       blink;
    logic [1:0] state;

    modport master (
        input  btn_pause, btn_rst, sw_adj, sw_sel,
        output ticker, cnt_clr, cnt_pause, cnt_sel, blink, state
    );

    modport slave (
        output btn_pause, btn_rst, sw_adj, sw_sel,
        input  ticker, cnt_clr, cnt_pause, cnt_sel, blink, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
`timescale 1ns/1ps
// Stopwatch control sequencer: debounced buttons/switches drive an IDLE/RUN/PAUSE/ADJUST FSM
// that produces tick, clear, pause, select and blink stimulus. Define STOPWATCH_CTRL_SIM_FAST_EN for short divisors.
module stopwatch_ctrl #(
    parameter int ONE_HZ_DIV = 100000000,
    parameter int ADJ_DIV    = 50000000,
    parameter int BLINK_DIV  = 25000000,
    parameter int DB_CYCLES  = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    stopwatch_ctrl_if.master io
);

`ifdef STOPWATCH_CTRL_SIM_FAST_EN
    localparam int ONE_EFF   = 10;
    localparam int ADJ_EFF   = 5;
    localparam int BLINK_EFF = 4;
    localparam int DB_EFF    = 2;
`else
    localparam int ONE_EFF   = ONE_HZ_DIV;
    localparam int ADJ_EFF   = ADJ_DIV;
    localparam int BLINK_EFF = BLINK_DIV;
    localparam int DB_EFF    = DB_CYCLES;
`endif

    localparam int TICK_MAX = (ONE_EFF > ADJ_EFF) ? ONE_EFF : ADJ_EFF;
    localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam int BLINK_W  = (BLINK_EFF > 1) ? $clog2(BLINK_EFF) : 1;
    localparam int DB_W     = (DB_EFF > 1) ? $clog2(DB_EFF) : 1;

    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DB_EFF - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_EFF - 1);
    localparam logic [TICK_W-1:0]  ONE_LAST   = TICK_W'(ONE_EFF - 1);
    localparam logic [TICK_W-1:0]  ADJ_LAST   = TICK_W'(ADJ_EFF - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSE  = 2'b10,
        ADJUST = 2'b11
    } state_t;

    // Bit order for all conditioning vectors: {sw_sel, sw_adj, btn_rst, btn_pause}
    logic [3:0]      raw;
    logic [3:0]      sync_p0;
    logic [3:0]      sync_p1;
    logic [3:0]      db_q;
    logic [DB_W-1:0] db_cnt [4];
    logic [1:0]      btn_prev;

    logic pp;
    logic rp;
    logic adj_db;
    logic sel_db;

    state_t state_q;
    state_t state_nxt;
    logic   state_chg;

    logic [TICK_W-1:0]  tick_cnt;
    logic [TICK_W-1:0]  tick_last;
    logic               tick_run;
    logic               ticker_q;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_run;
    logic               blink_q;
    logic               cnt_pause_q;
    logic               cnt_sel_q;

    assign raw = {io.sw_sel, io.sw_adj, io.btn_rst, io.btn_pause};

    // Stage boundary: 2-flop synchronizer, then a debouncer that needs DB_EFF stable mismatches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0  <= '0;
            sync_p1  <= '0;
            db_q     <= '0;
            btn_prev <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_p0  <= raw;
            sync_p1  <= sync_p0;
            btn_prev <= db_q[1:0];
            for (int i = 0; i < 4; i++) begin
                if (sync_p1[i] == db_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_q[i]   <= sync_p1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign pp     = db_q[0] & ~btn_prev[0];
    assign rp     = db_q[1] & ~btn_prev[1];
    assign adj_db = db_q[2];
    assign sel_db = db_q[3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // A clear press outranks everything, and a pause press in the same cycle is dropped.
    always_comb begin
        state_nxt = state_q;
        if (rp) begin
            state_nxt = (state_q == ADJUST) ? ADJUST : IDLE;
        end else if (adj_db && (state_q != ADJUST)) begin
            state_nxt = ADJUST;
        end else if ((state_q == ADJUST) && !adj_db) begin
            state_nxt = PAUSE;
        end else if (pp) begin
            case (state_q)
                IDLE:    state_nxt = RUN;
                RUN:     state_nxt = PAUSE;
                PAUSE:   state_nxt = RUN;
                default: state_nxt = state_q;
            endcase
        end
    end

    assign state_chg = (state_nxt != state_q);
    assign tick_run  = (state_q == RUN) || (state_q == ADJUST);
    assign tick_last = (state_q == ADJUST) ? ADJ_LAST : ONE_LAST;
    assign blink_run = (state_q == ADJUST) && (state_nxt == ADJUST);

    // Stage boundary: tick divider restarts on every state change so a period always starts at entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            ticker_q <= 1'b0;
        end else if (state_chg || rp || !tick_run) begin
            tick_cnt <= '0;
            ticker_q <= 1'b0;
        end else if (tick_cnt == tick_last) begin
            tick_cnt <= '0;
            ticker_q <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
            ticker_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (!blink_run) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_q   <= ~blink_q;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Stage boundary: Counter level controls follow the state register by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_pause_q <= 1'b1;
            cnt_sel_q   <= 1'b0;
        end else begin
            cnt_pause_q <= !((state_q == RUN) || (state_q == ADJUST));
            cnt_sel_q   <= (state_q == ADJUST) && sel_db;
        end
    end

    assign io.ticker    = ticker_q;
    assign io.cnt_clr   = rp;
    assign io.cnt_pause = cnt_pause_q;
    assign io.cnt_sel   = cnt_sel_q;
    assign io.blink     = blink_q;
    assign io.state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
`timescale 1ns/1ps
// Bench for stopwatch_ctrl with short divisors (tick 10 / adjust 5 / blink 4 / debounce 2).
module tb_stopwatch_ctrl;

    typedef struct {
        logic       pause;
        logic       rst;
        logic       adj;
        logic       sel;
        int         hold;
        logic [1:0] st;
        logic       cp;
        logic       cs;
        logic       bl;
        int         ticks;
        int         clrs;
    } vec_t;

    logic clk;
    logic rst_n;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(
        .ONE_HZ_DIV (10),
        .ADJ_DIV    (5),
        .BLINK_DIV  (4),
        .DB_CYCLES  (2)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .io    (bus)
    );

    int         n_cmp   = 0;
    int         n_bad   = 0;
    int         cyc     = 0;
    int         n_ticks = 0;
    int         n_clrs  = 0;
    int         n_trans = 0;
    int         rd_idx  = 0;
    logic       sb_on   = 1'b0;
    logic [1:0] last_state = 2'b00;
    int         got[$];
    int         exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observe just after each rising edge: cycle index, tick arrivals, clear pulses, state changes.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (bus.ticker === 1'b1) begin
                n_ticks = n_ticks + 1;
                if (sb_on) got.push_back(cyc);
            end
            if (bus.cnt_clr === 1'b1) n_clrs = n_clrs + 1;
            if (bus.state !== last_state) n_trans = n_trans + 1;
            last_state = bus.state;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_state"},     bus.state,     2'b00);
        check({pfx, "_cnt_pause"}, bus.cnt_pause, 1'b1);
        check({pfx, "_ticker"},    bus.ticker,    1'b0);
        check({pfx, "_cnt_clr"},   bus.cnt_clr,   1'b0);
        check({pfx, "_cnt_sel"},   bus.cnt_sel,   1'b0);
        check({pfx, "_blink"},     bus.blink,     1'b0);
    endtask

    task automatic sb_drain(input string nm);
        int e;
        check({nm, "_tick_count"}, got.size() - rd_idx, exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_idx < got.size()) begin
                check({nm, "_tick_cycle"}, got[rd_idx], e);
                rd_idx = rd_idx + 1;
            end
        end
        rd_idx = got.size();
    endtask

    task automatic press_pause(output int f);
        f = cyc;
        bus.btn_pause = 1'b1;
        repeat (6) @(negedge clk);
        bus.btn_pause = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        vec_t vecs [9];
        int   t0, c0, tr0, c, d, e, f, g, j;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0,  8, 2'b00, 1'b1, 1'b0, 1'b0, 0, 0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 12, 2'b01, 1'b0, 1'b0, 1'b0, 0, 0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 12, 2'b01, 1'b0, 1'b0, 1'b0, 1, 0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 12, 2'b10, 1'b1, 1'b0, 1'b0, 1, 0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 12, 2'b10, 1'b1, 1'b0, 1'b0, 0, 0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 12, 2'b11, 1'b0, 1'b1, 1'b1, 1, 0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 12, 2'b10, 1'b1, 1'b0, 1'b0, 1, 0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 12, 2'b00, 1'b1, 1'b0, 1'b0, 0, 1};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 12, 2'b00, 1'b1, 1'b0, 1'b0, 0, 0};

        rst_n         = 1'b0;
        bus.btn_pause = 1'b0;
        bus.btn_rst   = 1'b0;
        bus.sw_adj    = 1'b0;
        bus.sw_sel    = 1'b0;
        #50;
        check_reset_vals("in_reset");
        #50;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("after_reset");

        for (int i = 0; i < 9; i++) begin
            bus.btn_pause = vecs[i].pause;
            bus.btn_rst   = vecs[i].rst;
            bus.sw_adj    = vecs[i].adj;
            bus.sw_sel    = vecs[i].sel;
            t0 = n_ticks;
            c0 = n_clrs;
            repeat (vecs[i].hold) @(negedge clk);
            check($sformatf("v%0d_state", i),     bus.state,     vecs[i].st);
            check($sformatf("v%0d_cnt_pause", i), bus.cnt_pause, vecs[i].cp);
            check($sformatf("v%0d_cnt_sel", i),   bus.cnt_sel,   vecs[i].cs);
            check($sformatf("v%0d_blink", i),     bus.blink,     vecs[i].bl);
            check($sformatf("v%0d_ticks", i),     n_ticks - t0,  vecs[i].ticks);
            check($sformatf("v%0d_clrs", i),      n_clrs - c0,   vecs[i].clrs);
        end

        // Start from IDLE: RUN five cycles after the press, ticks every 10 cycles after entry.
        sb_on = 1'b1;
        c = cyc;
        exp_q.push_back(c + 15);
        exp_q.push_back(c + 25);
        exp_q.push_back(c + 35);
        bus.btn_pause = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 4) check("start_still_idle", bus.state, 2'b00);
            if (k == 5) begin
                check("start_run", bus.state, 2'b01);
                check("start_pause_lag", bus.cnt_pause, 1'b1);
            end
            if (k == 6) check("start_pause_low", bus.cnt_pause, 1'b0);
        end
        bus.btn_pause = 1'b0;
        repeat (26) @(negedge clk);
        sb_drain("run_ticks");

        // Bouncing press: exactly one RUN->PAUSE change, no ticks once paused.
        d   = cyc;
        tr0 = n_trans;
        exp_q.push_back(d + 9);
        for (int b = 0; b < 4; b++) begin
            bus.btn_pause = 1'b1;
            @(negedge clk);
            bus.btn_pause = 1'b0;
            @(negedge clk);
        end
        bus.btn_pause = 1'b1;
        for (int k = 9; k <= 30; k++) begin
            @(negedge clk);
            if (k == 12) check("bounce_still_run", bus.state, 2'b01);
            if (k == 13) check("bounce_paused", bus.state, 2'b10);
        end
        check("bounce_transitions", n_trans - tr0, 1);
        check("bounce_state_end", bus.state, 2'b10);
        bus.btn_pause = 1'b0;
        repeat (6) @(negedge clk);
        sb_drain("bounce_ticks");

        // Clear and pause pressed together while running: clear wins.
        press_pause(f);
        exp_q.push_back(f + 15);
        check("clr_pre_run", bus.state, 2'b01);
        e  = cyc;
        c0 = n_clrs;
        bus.btn_rst   = 1'b1;
        bus.btn_pause = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 4) begin
                check("clr_pulse_high", bus.cnt_clr, 1'b1);
                check("clr_state_before", bus.state, 2'b01);
            end
            if (k == 5) begin
                check("clr_pulse_low", bus.cnt_clr, 1'b0);
                check("clr_state_idle", bus.state, 2'b00);
            end
        end
        check("clr_pulse_count", n_clrs - c0, 1);
        check("clr_pp_dropped", bus.state, 2'b00);
        bus.btn_rst   = 1'b0;
        bus.btn_pause = 1'b0;
        repeat (6) @(negedge clk);
        sb_drain("clr_ticks");

        // Adjust mode: 5-cycle ticks, blink toggling every 4 cycles, then exit to PAUSE.
        g = cyc;
        exp_q.push_back(g + 10);
        exp_q.push_back(g + 15);
        exp_q.push_back(g + 20);
        exp_q.push_back(g + 25);
        bus.sw_adj = 1'b1;
        bus.sw_sel = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 4) check("adj_not_yet", bus.state, 2'b00);
            if (k >= 5 && k <= 22) begin
                check($sformatf("adj_state_k%0d", k), bus.state, 2'b11);
                check($sformatf("adj_blink_k%0d", k), bus.blink, ((k - 5) / 4) % 2);
            end
            if (k == 10) begin
                check("adj_cnt_sel", bus.cnt_sel, 1'b1);
                check("adj_cnt_pause", bus.cnt_pause, 1'b0);
            end
            if (k == 22) bus.sw_adj = 1'b0;
            if (k == 26) check("adj_exit_pending", bus.state, 2'b11);
            if (k == 27) begin
                check("adj_exit_pause", bus.state, 2'b10);
                check("adj_exit_blink", bus.blink, 1'b0);
            end
            if (k == 28) check("adj_exit_sel", bus.cnt_sel, 1'b0);
        end
        check("adj_end_cnt_pause", bus.cnt_pause, 1'b1);
        check("adj_end_blink", bus.blink, 1'b0);
        bus.sw_sel = 1'b0;
        repeat (6) @(negedge clk);
        sb_drain("adj_ticks");

        // Asynchronous reset pulse 7 cycles into a RUN tick period.
        press_pause(f);
        check("areset_pre_run", bus.state, 2'b01);
        rst_n = 1'b0;
        #2;
        check_reset_vals("areset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("areset_idle", bus.state, 2'b00);
        sb_drain("areset_quiet");
        press_pause(j);
        exp_q.push_back(j + 15);
        exp_q.push_back(j + 25);
        repeat (15) @(negedge clk);
        check("areset_rerun", bus.state, 2'b01);
        sb_drain("areset_ticks");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
